uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered, parametrised UART transmitter; successor to uart_tx.
//  Accepts bytes through a valid/ready write port into an internal FIFO and serialises them back-to-back.
//  Frame format is configurable: data bits, parity, stop bits and line inversion (inverted F.Port/S.Bus links).
//  Used for the debug telemetry port and as the RC stream player in simulation benches.
// PARAMETERS
//  CLKS_PER_BIT  87  clock cycles per bit period; legal range >=2
//  DATA_BITS     8   payload bits per frame; legal range 5..9
//  PARITY        0   parity mode: 0 none, 1 odd, 2 even
//  STOP_BITS     1   stop bits per frame; legal values 1 or 2
//  INVERT        0   1 = line inverted: idle and stop drive 0, start drives 1, data and parity bits complemented
//  FIFO_DEPTH    16  FIFO entries; power of two, >=2
// PORTS
//  clock         in   1                     system clock, rising edge
//  rst_n         in   1                     asynchronous, active-low reset
//  wrData        in   DATA_BITS             byte to enqueue
//  wrValid       in   1                     enqueue request
//  wrReady       out  1                     FIFO not full
//  clrOverflow   in   1                     clears overflow flag
//  overflow      out  1                     sticky flag: a write was dropped
//  fifoCount     out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  txOut         out  1                     serial line
//  busy          out  1                     a frame is in progress
//  sendComplete  out  1                     1-cycle pulse at the end of each frame
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO flushed; fifoCount=0, wrReady=1, overflow=0.
//   - busy=0, sendComplete=0; FSM returns to IDLE.
//   - txOut goes to the idle level (1, or 0 if INVERT) immediately, including mid-frame. The partial frame is abandoned.
//  Write:
//   - wrReady = (fifoCount != FIFO_DEPTH), derived from registered state only.
//   - A push occurs when wrValid && wrReady at a rising edge.
//   - wrValid && !wrReady: data dropped, overflow<=1.
//   - overflow holds until clrOverflow=1. If a drop and clrOverflow occur in the same cycle, overflow is 1 (set wins).
//   - Push and pop in the same cycle: count unchanged. A full FIFO still rejects that cycle's write.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: busy=0. If fifoCount!=0: pop head into shift register, go to START.
//     Pop of an entry written at edge N happens at edge N+1; the start bit appears on txOut from edge N+2.
//   - START: drive start level for CLKS_PER_BIT cycles.
//   - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
//   - PARITY: entered only if PARITY!=0. Bit value is ^data for even parity, ~^data for odd, then INVERT is applied.
//   - STOP: stop level for STOP_BITS*CLKS_PER_BIT cycles.
//     sendComplete pulses on the last cycle of STOP.
//     If the FIFO is non-empty at that edge, pop and go directly to START (no idle gap); otherwise go to IDLE.
//  Timing and registers:
//   - Bit timer counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
//   - Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, exactly.
//   - busy=1 from the pop edge through the last STOP cycle.
//   - txOut is registered (no glitches).
//  FIFO pointers:
//   - $clog2(FIFO_DEPTH) bits, wrapping naturally.
//   - Count is held separately so the full and empty states are unambiguous.
//  Inputs are sampled only at rising clock edges. wrData is don't-care when wrValid=0.
// TESTING
//  1. CLKS_PER_BIT=4, 8N1: write 0xA5 at edge 10
//     -> start bit at edge 12; txOut bits 1,0,1,0,0,1,0,1 every 4 cycles; stop; sendComplete pulse at edge 51.
//  2. Write 3 bytes in consecutive cycles
//     -> 3 frames with no gap (120 cycles total); busy high throughout; 3 sendComplete pulses.
//  3. FIFO_DEPTH=4: 6 writes in consecutive cycles while idle
//     -> the 5 accepted (one popped mid-burst) are sent; the 6th is dropped, wrReady=0, overflow=1 until clrOverflow.
//  4. PARITY=2 (even), 0x07 -> parity bit 1; PARITY=1 (odd), 0x07 -> parity bit 0. STOP_BITS=2 extends the stop by CLKS_PER_BIT.
//  5. INVERT=1, send 0x00 -> idle 0, start 1, data 1s, stop 0. Compare against uart_rx on ~txOut.
//  6. Assert rst_n low mid-DATA with 2 bytes queued
//     -> txOut=idle level at once, fifoCount=0; after release, no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding a configurable serialiser (data/parity/stop/invert).
// Start bit appears two edges after a push into an empty idle FIFO; wrReady drops only when the FIFO is full.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int INVERT       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          wrData,
  input  logic                          wrValid,
  output logic                          wrReady,
  input  logic                          clrOverflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          txOut,
  output logic                          busy,
  output logic                          sendComplete
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic IDLE_LVL = (INVERT != 0) ? 1'b0 : 1'b1;
  localparam logic INV      = (INVERT != 0);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 push, pop, bit_end, stop_end;

  assign wrReady  = (count_q != FULL_CNT);
  assign push     = wrValid && wrReady;
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign stop_end = (state_q == S_STOP) && bit_end && (bit_q == BW'(STOP_BITS - 1));
  // The end of a frame can pop the next entry directly, giving back-to-back frames.
  assign pop      = (count_q != '0) && ((state_q == S_IDLE) || stop_end);

  always_comb begin
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (wrValid && !wrReady) begin
      ovf_d = 1'b1;
    end else if (clrOverflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // txOut is computed from the current state and lands one edge later, so the
  // line trails the FSM by exactly one cycle for every bit.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = IDLE_LVL;
    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end
    case (state_q)
      S_IDLE: tx_d = IDLE_LVL;
      S_START: begin
        tx_d = ~IDLE_LVL;
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0] ^ INV;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        tx_d = par_q ^ INV;
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        tx_d = IDLE_LVL;
        if (stop_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          bit_d   = '0;
        end else if (bit_end) begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      timer_d = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (PARITY == 2) ? ^head : ~^head;
    end
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wrData;
    end
  end

  assign overflow     = ovf_q;
  assign fifoCount    = count_q;
  assign txOut        = tx_q;
  assign busy         = busy_q;
  assign sendComplete = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame configurations, a frame scoreboard per instance,
// line monitors that decode each frame cycle by cycle.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] wd   [3];
  logic       wv   [3];
  logic       clr  [3];
  logic       rdy  [3];
  logic       ovf  [3];
  logic       tx   [3];
  logic       busy [3];
  logic       done [3];
  logic [2:0] cnt  [3];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int frames        [3] = '{0, 0, 0};
  int last_start    [3] = '{0, 0, 0};
  int last_done_cyc [3] = '{0, 0, 0};
  int last_wr_edge  [3] = '{0, 0, 0};
  int done_cnt      [3] = '{0, 0, 0};
  logic [15:0] last_bits [3];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  logic [7:0] t3_dat [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic       t3_acc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) if (done[i] === 1'b1) done_cnt[i]++;
  end

  // a: 8N1, b: 8E2 inverted, c: 7O1
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .INVERT(0), .FIFO_DEPTH(4)) dut_a (
    .clock(clock), .rst_n(rst_n), .wrData(wd[0][7:0]), .wrValid(wv[0]), .wrReady(rdy[0]),
    .clrOverflow(clr[0]), .overflow(ovf[0]), .fifoCount(cnt[0]), .txOut(tx[0]), .busy(busy[0]),
    .sendComplete(done[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .INVERT(1), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .rst_n(rst_n), .wrData(wd[1][7:0]), .wrValid(wv[1]), .wrReady(rdy[1]),
    .clrOverflow(clr[1]), .overflow(ovf[1]), .fifoCount(cnt[1]), .txOut(tx[1]), .busy(busy[1]),
    .sendComplete(done[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .INVERT(0), .FIFO_DEPTH(4)) dut_c (
    .clock(clock), .rst_n(rst_n), .wrData(wd[2][6:0]), .wrValid(wv[2]), .wrReady(rdy[2]),
    .clrOverflow(clr[2]), .overflow(ovf[2]), .fifoCount(cnt[2]), .txOut(tx[2]), .busy(busy[2]),
    .sendComplete(done[2]));

  function automatic int dbits(input int w);
    return (w == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(input int w);
    return (w == 0) ? 0 : ((w == 1) ? 2 : 1);
  endfunction
  function automatic int nstop(input int w);
    return (w == 1) ? 2 : 1;
  endfunction
  function automatic logic inv(input int w);
    return (w == 1);
  endfunction
  function automatic logic idle_lvl(input int w);
    return ~inv(w);
  endfunction
  function automatic int nbits(input int w);
    return 1 + dbits(w) + ((pmode(w) != 0) ? 1 : 0) + nstop(w);
  endfunction
  function automatic string nm(input int w);
    return (w == 0) ? "a" : ((w == 1) ? "b" : "c");
  endfunction

  // Expected line level for each bit slot, slot 0 = start bit.
  function automatic logic [15:0] frame_of(input int w, input logic [8:0] d);
    logic [15:0] f;
    logic        p;
    int          pos;
    f = '0;
    p = 1'b0;
    f[0] = inv(w);
    for (int i = 0; i < dbits(w); i++) begin
      f[1+i] = d[i] ^ inv(w);
      p      = p ^ d[i];
    end
    pos = 1 + dbits(w);
    if (pmode(w) == 2) begin
      f[pos] = p ^ inv(w);
      pos++;
    end else if (pmode(w) == 1) begin
      f[pos] = ~p ^ inv(w);
      pos++;
    end
    for (int k = 0; k < nstop(w); k++) f[pos+k] = ~inv(w);
    return f;
  endfunction

  function automatic int sb_size(input int w);
    case (w)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction
  function automatic logic [15:0] sb_pop(input int w);
    case (w)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction
  task automatic sb_push(input int w, input logic [15:0] f);
    case (w)
      0: q0.push_back(f);
      1: q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; the write is captured at the next edge.
  task automatic wr(input int w, input logic [8:0] d, input logic acc, input logic c);
    wv[w]  = 1'b1;
    wd[w]  = d;
    clr[w] = c;
    if (acc) sb_push(w, frame_of(w, d));
    @(negedge clock);
    chk({"wr_ready_", nm(w)}, rdy[w], acc);
    last_wr_edge[w] = cyc + 1;
    @(posedge clock);
    #1;
    wv[w]  = 1'b0;
    clr[w] = 1'b0;
    wd[w]  = '0;
  endtask

  task automatic wait_frames(input int w, input int target, input int budget);
    int k;
    k = 0;
    while (frames[w] < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk({"frames_", nm(w)}, frames[w], target);
    @(negedge clock);
  endtask

  // Decodes one frame per start bit, sampling every cycle of every bit slot.
  task automatic monitor(input int w);
    logic [15:0] got;
    logic [15:0] exp;
    int          bad_w, bad_b, done_at, nb;
    logic        aborted;
    nb = nbits(w);
    forever begin
      @(negedge clock);
      if (rst_n === 1'b1 && tx[w] !== idle_lvl(w)) begin
        got = '0; bad_w = 0; bad_b = 0; done_at = -1; aborted = 1'b0;
        last_start[w] = cyc;
        for (int i = 0; i < nb * CPB && !aborted; i++) begin
          if (i != 0) @(negedge clock);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            if (i % CPB == 0) got[i/CPB] = tx[w];
            else if (tx[w] !== got[i/CPB]) bad_w++;
            if (busy[w] !== 1'b1) bad_b++;
            if (done[w] === 1'b1) begin
              if (done_at < 0) begin
                done_at = i;
                last_done_cyc[w] = cyc;
              end else begin
                bad_w++;
              end
            end
          end
        end
        if (!aborted) begin
          chk({"frame_expected_", nm(w)}, sb_size(w) > 0, 1);
          if (sb_size(w) > 0) begin
            exp = sb_pop(w);
            chk({"frame_bits_", nm(w)}, got, exp);
          end
          chk({"bit_width_", nm(w)}, bad_w, 0);
          chk({"busy_in_frame_", nm(w)}, bad_b, 0);
          chk({"done_pos_", nm(w)}, done_at, nb * CPB - 1);
          last_bits[w] = got;
          frames[w]++;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w1, w3, w6, f0, fb, fc, dc;
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1'b0; clr[i] = 1'b0; wd[i] = '0;
    end
    repeat (3) @(negedge clock);
    chk("rst_tx_a", tx[0], 1);
    chk("rst_tx_b", tx[1], 0);
    chk("rst_rdy_a", rdy[0], 1);
    chk("rst_cnt_a", cnt[0], 0);
    chk("rst_ovf_a", ovf[0], 0);
    chk("rst_busy_a", busy[0], 0);
    chk("rst_done_a", done[0], 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // single 8N1 frame with exact edge timing
    wr(0, 9'h0A5, 1'b1, 1'b0);
    w1 = last_wr_edge[0];
    wait_frames(0, 1, 200);
    chk("t1_start_edge", last_start[0], w1 + 2);
    chk("t1_done_edge", last_done_cyc[0], w1 + 41);
    chk("t1_line_bits", last_bits[0], 16'h034A);

    // three back-to-back frames
    tick();
    f0 = frames[0];
    dc = done_cnt[0];
    wr(0, 9'h03C, 1'b1, 1'b0);
    w1 = last_wr_edge[0];
    wr(0, 9'h081, 1'b1, 1'b0);
    wr(0, 9'h0FF, 1'b1, 1'b0);
    wait_frames(0, f0 + 3, 300);
    chk("t2_third_start", last_start[0], w1 + 82);
    chk("t2_last_done", last_done_cyc[0], w1 + 121);
    chk("t2_done_pulses", done_cnt[0] - dc, 3);
    chk("t2_idle_busy", busy[0], 0);

    // overflow on a 4-deep FIFO, drop and clear in the same cycle
    tick();
    f0 = frames[0];
    w3 = 0;
    for (int i = 0; i < 6; i++) begin
      wr(0, {1'b0, t3_dat[i]}, t3_acc[i], (i == 5));
      if (i == 0) w3 = last_wr_edge[0];
    end
    @(negedge clock);
    chk("t3_count_full", cnt[0], 4);
    chk("t3_ovf_set_wins", ovf[0], 1);
    chk("t3_rdy_full", rdy[0], 0);
    repeat (10) @(negedge clock);
    chk("t3_ovf_sticky", ovf[0], 1);
    clr[0] = 1'b1;
    @(negedge clock);
    clr[0] = 1'b0;
    chk("t3_ovf_cleared", ovf[0], 0);
    while (cyc < w3 + 40) tick();
    wr(0, 9'h077, 1'b0, 1'b0);
    @(negedge clock);
    chk("t3_full_pop_count", cnt[0], 3);
    chk("t3_full_pop_ovf", ovf[0], 1);
    clr[0] = 1'b1;
    @(negedge clock);
    clr[0] = 1'b0;
    wait_frames(0, f0 + 5, 400);

    // parity, two stop bits, inverted line
    tick();
    fb = frames[1];
    fc = frames[2];
    wr(1, 9'h007, 1'b1, 1'b0);
    wr(1, 9'h000, 1'b1, 1'b0);
    wr(2, 9'h007, 1'b1, 1'b0);
    wait_frames(1, fb + 1, 200);
    chk("t4_even_inv_0x07", last_bits[1], 16'h01F1);
    wait_frames(2, fc + 1, 200);
    chk("t4_odd_7bit_0x07", last_bits[2], 16'h020E);
    wait_frames(1, fb + 2, 200);
    chk("t5_inv_0x00", last_bits[1], 16'h03FF);
    chk("t5_inv_idle", tx[1], 0);

    // reset mid-DATA with two bytes still queued
    tick();
    f0 = frames[0];
    wr(0, 9'h05A, 1'b1, 1'b0);
    w6 = last_wr_edge[0];
    wr(0, 9'h0C3, 1'b1, 1'b0);
    wr(0, 9'h00F, 1'b1, 1'b0);
    while (cyc < w6 + 15) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_tx_idle_now", tx[0], 1);
    chk("t6_count_flushed", cnt[0], 0);
    chk("t6_busy_clear", busy[0], 0);
    chk("t6_rdy_set", rdy[0], 1);
    q0.delete();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (100) @(negedge clock);
    chk("t6_no_more_frames", frames[0], f0);
    chk("t6_tx_idle_after", tx[0], 1);
    chk("t6_count_after", cnt[0], 0);
    chk("sb_left_b", sb_size(1), 0);
    chk("sb_left_c", sb_size(2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
